serial_frame_rx: RTL

Serial frame receiver that sits directly downstream of the single-bit D flip-flop stage. It consumes the registered Q bit stream, one bit per clk, and detects start/stop framing. It assembles DATA_W data bits (LSB first), checks even parity, and presents a parallel word with a one-cycle valid strobe. Error flags feed the status logic.

---
 rtl/serial_frame_rx.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, optional
// even parity bit, stop bit. Emits a parallel word plus one-cycle strobes.
//
// Ports:
//   clk        - system clock, all state updates on the rising edge
//   rst        - synchronous active-high reset
//   din        - serial bit, sampled every rising edge, idle level 1
//   data_out   - last correctly framed word, held until the next good frame
//   data_valid - one-cycle pulse when data_out is updated
//   parity_err - one-cycle pulse alongside data_valid on parity mismatch
//   frame_err  - one-cycle pulse when the stop bit is sampled low
//   busy       - high while a frame is in progress
module serial_frame_rx #(
  parameter int DATA_W    = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_shift;
  logic                r_par;
  logic [DATA_W-1:0]   r_dout;
  logic                r_valid;
  logic                r_perr;
  logic                r_ferr;
  logic                r_busy;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [DATA_W-1:0]   w_shift_nxt;
  logic                w_par_nxt;
  logic [DATA_W-1:0]   w_dout_nxt;
  logic                w_valid_nxt;
  logic                w_perr_nxt;
  logic                w_ferr_nxt;
  logic                w_busy_nxt;
  logic                w_last_bit;

  assign w_last_bit = (r_cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
      r_dout  <= w_dout_nxt;
      r_valid <= w_valid_nxt;
      r_perr  <= w_perr_nxt;
      r_ferr  <= w_ferr_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_dout_nxt  = r_dout;
    w_valid_nxt = 1'b0;
    w_perr_nxt  = 1'b0;
    w_ferr_nxt  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (!din) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = '0;
        end
      end
      S_DATA: begin
        // Right shift: after DATA_W bits the first bit sits in bit 0.
        w_shift_nxt = {din, r_shift[DATA_W-1:1]};
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        if (w_last_bit) begin
          w_state_nxt = PARITY_EN ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        w_par_nxt   = din;
        w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (din) begin
          w_dout_nxt  = r_shift;
          w_valid_nxt = 1'b1;
          w_perr_nxt  = PARITY_EN & (^r_shift ^ r_par);
          w_state_nxt = S_IDLE;
        end else begin
          w_ferr_nxt  = 1'b1;
          w_state_nxt = S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        // A held-low line must not be mistaken for a new start bit.
        if (din) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Stays high for the cycle after the stop edge so the strobe
    // cycle is still flagged as part of the frame.
    w_busy_nxt = (w_state_nxt != S_IDLE) || (r_state == S_STOP);
  end

  assign data_out   = r_dout;
  assign data_valid = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign busy       = r_busy;

endmodule
